// File: rtl/regfile_sb_pkg.sv
// subarashii_pkg: shared defaults and clear-FSM state encoding for regfile_sb.
// Revision: 1.0 - initial release
`default_nettype none

package subarashii_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: writeback, read, issue and clear signals of regfile_sb.
// Revision: 1.0 - initial release
`default_nettype none

interface regfile_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic              wen;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] rd;
  logic [ADDR_W-1:0] sel_ra;
  logic [ADDR_W-1:0] sel_rb;
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] rb;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              clr_req;
  logic              busy;
  logic              stall_a;
  logic              stall_b;

  modport master (
    output wen, sel_rd, rd, sel_ra, sel_rb, iss_valid, iss_rd, clr_req,
    input  ra, rb, busy, stall_a, stall_b
  );

  modport slave (
    input  wen, sel_rd, rd, sel_ra, sel_rb, iss_valid, iss_rd, clr_req,
    output ra, rb, busy, stall_a, stall_b
  );

endinterface

`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits and read-port stall logic.
// Revision: 1.0 - initial release
`default_nettype none

module regfile_scoreboard #(
  parameter int ADDR_W = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_busy,
  input  wire logic              i_wr_eff,
  input  wire logic [ADDR_W-1:0] i_wr_idx,
  input  wire logic              i_iss_eff,
  input  wire logic [ADDR_W-1:0] i_iss_idx,
  input  wire logic [ADDR_W-1:0] i_sweep_idx,
  input  wire logic [ADDR_W-1:0] i_sel_a,
  input  wire logic [ADDR_W-1:0] i_sel_b,
  output logic                   o_stall_a,
  output logic                   o_stall_b
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] r_pend;
  logic             w_hit_a;
  logic             w_hit_b;

  // Issue is applied after the writeback clear so a new producer wins on the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else if (i_busy) begin
      r_pend[i_sweep_idx] <= 1'b0;
    end else begin
      if (i_wr_eff)
        r_pend[i_wr_idx] <= 1'b0;
      if (i_iss_eff)
        r_pend[i_iss_idx] <= 1'b1;
    end
  end

  assign w_hit_a   = i_wr_eff & (i_wr_idx == i_sel_a);
  assign w_hit_b   = i_wr_eff & (i_wr_idx == i_sel_b);
  assign o_stall_a = i_busy | (r_pend[i_sel_a] & ~w_hit_a);
  assign o_stall_b = i_busy | (r_pend[i_sel_b] & ~w_hit_b);

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// regfile_sb: 1W/2R register file with bypass, pending scoreboard and clear sweep.
// Optional REGFILE_ZERO_REG_EN hardwires register 0 to zero. Revision: 1.0
`default_nettype none

module regfile_sb
  import subarashii_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  wire logic   clk,
  input  wire logic   rst,
  regfile_sb_if.slave bus
);

  localparam int                NREGS  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NREGS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_busy;
  logic              w_wr_eff;
  logic              w_iss_eff;
  logic              w_hit_a;
  logic              w_hit_b;

`ifdef REGFILE_ZERO_REG_EN
  assign w_wr_eff  = bus.wen & ~w_busy & (bus.sel_rd != '0);
  assign w_iss_eff = bus.iss_valid & ~w_busy & (bus.iss_rd != '0);
`else
  assign w_wr_eff  = bus.wen & ~w_busy;
  assign w_iss_eff = bus.iss_valid & ~w_busy;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.clr_req)     w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (r_idx == c_LAST) w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == ST_SWEEP);
  end

  // Held at zero in IDLE; the last sweep step wraps it back to zero naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_idx <= '0;
    else if (r_state == ST_IDLE)
      r_idx <= '0;
    else
      r_idx <= r_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else if (w_busy) begin
      r_regs[r_idx] <= '0;
    end else if (w_wr_eff) begin
      r_regs[bus.sel_rd] <= bus.rd;
    end
  end

  // Index 0 is never written when zero-reg is enabled, so the plain array read yields 0.
  assign w_hit_a = w_wr_eff & (bus.sel_rd == bus.sel_ra);
  assign w_hit_b = w_wr_eff & (bus.sel_rd == bus.sel_rb);
  assign bus.ra  = w_hit_a ? bus.rd : r_regs[bus.sel_ra];
  assign bus.rb  = w_hit_b ? bus.rd : r_regs[bus.sel_rb];
  assign bus.busy = w_busy;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_busy      (w_busy),
    .i_wr_eff    (w_wr_eff),
    .i_wr_idx    (bus.sel_rd),
    .i_iss_eff   (w_iss_eff),
    .i_iss_idx   (bus.iss_rd),
    .i_sweep_idx (r_idx),
    .i_sel_a     (bus.sel_ra),
    .i_sel_b     (bus.sel_rb),
    .o_stall_a   (bus.stall_a),
    .o_stall_b   (bus.stall_b)
  );

endmodule

`default_nettype wire
